// File: rtl/rsnn_pkg.sv
// Shared RSNN datapath types: scan FSM states and the
// signed-8 saturation used by synapse and neuron clamps.
package rsnn_pkg;

  localparam int W_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  function automatic logic signed [7:0] sat8(
    input logic signed [31:0] v
  );
    if (v > 32'sd127)
      return 8'sh7f;
    else if (v < -32'sd128)
      return 8'sh80;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/synapse_weight_rf.sv
// N x W synaptic weight register file: one write port,
// one combinational read port, async active-low clear.
module synapse_weight_rf #(
  parameter int N  = 8,
  parameter int W  = 8,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/synaptic_current_integrator.sv
// Serial spike-weighted current integrator feeding the LIF neuron.
// Optional exponential trace: define SYN_CURRENT_DECAY_EN.
module synaptic_current_integrator
  import rsnn_pkg::*;
#(
  parameter int N_INPUTS = 8,
  parameter int W_WIDTH  = W_WIDTH_DEF,
  localparam int IW = $clog2(N_INPUTS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [N_INPUTS-1:0] spikes_in,
  input  logic                w_wr_en,
  input  logic [IW-1:0]       w_addr,
  input  logic [W_WIDTH-1:0]  w_data,
  output logic                busy,
  output logic [W_WIDTH-1:0]  current_out,
  output logic                current_valid
);

  localparam int ACC_WIDTH = W_WIDTH + IW + 1;
  localparam int XW = ACC_WIDTH - W_WIDTH;

  state_t state, state_nx;

  logic [N_INPUTS-1:0]        snap;
  logic [IW-1:0]              idx;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] total;
  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [31:0]         total32;
  logic [W_WIDTH-1:0]         rd_w;
  logic                       last;

  synapse_weight_rf #(
    .N(N_INPUTS),
    .W(W_WIDTH)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (w_wr_en),
    .wr_addr(w_addr),
    .wr_data(w_data),
    .rd_addr(idx),
    .rd_data(rd_w)
  );

  assign last  = (idx == IW'(N_INPUTS - 1));
  assign w_ext = {{XW{rd_w[W_WIDTH-1]}}, rd_w};

`ifdef SYN_CURRENT_DECAY_EN
  // previous current halved, floored toward -inf
  assign total = acc + {{(XW + 1){current_out[W_WIDTH-1]}},
                        current_out[W_WIDTH-1:1]};
`else
  assign total = acc;
`endif

  assign total32 = {{(32 - ACC_WIDTH){total[ACC_WIDTH-1]}}, total};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (tick) state_nx = SCAN;
      SCAN:    if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE) || current_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap          <= '0;
      idx           <= '0;
      acc           <= '0;
      current_out   <= '0;
      current_valid <= 1'b0;
    end else begin
      current_valid <= (state == DONE);
      unique case (1'b1)
        (state == IDLE): begin
          if (tick) begin
            snap <= spikes_in;
            acc  <= '0;
            idx  <= '0;
          end
        end
        (state == SCAN): begin
          if (snap[idx]) acc <= acc + w_ext;
          if (!last) idx <= idx + 1'b1;
        end
        (state == DONE): begin
          current_out <= W_WIDTH'(sat8(total32));
        end
        default: ;
      endcase
    end
  end

endmodule
